// File: rtl/sb_cfg_pkg.sv
// Shared definitions for the switch-box configuration loader: config width,
// loader state encoding and the bit positions of the switch-box `c` bus.
package sb_cfg_pkg;

  localparam int unsigned CFG_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  // Connection-enable bit indices within one element's `c` bus.
  localparam int unsigned C_N0_E0 = 0;
  localparam int unsigned C_E1_S0 = 1;
  localparam int unsigned C_S0_W0 = 2;
  localparam int unsigned C_W0_N1 = 3;
  localparam int unsigned C_N1_E1 = 4;
  localparam int unsigned C_E0_S1 = 5;
  localparam int unsigned C_S1_W1 = 6;
  localparam int unsigned C_N0_S0 = 7;
  localparam int unsigned C_E0_W0 = 8;
  localparam int unsigned C_N1_S1 = 9;
  localparam int unsigned C_E1_W1 = 10;
  localparam int unsigned C_W1_N0 = 11;

endpackage

// File: rtl/sb_config_loader_if.sv
// Serial configuration port: start/abort control, bit-serial valid/ready
// data stream and loader status.
interface sb_config_loader_if;
  logic cfg_start;
  logic cfg_abort;
  logic cfg_bit;
  logic cfg_valid;
  logic cfg_ready;
  logic busy;
  logic cfg_done;

  modport master (
    output cfg_start, cfg_abort, cfg_bit, cfg_valid,
    input  cfg_ready, busy, cfg_done
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_bit, cfg_valid,
    output cfg_ready, busy, cfg_done
  );
endinterface

// File: rtl/sb_cfg_shift_reg.sv
// Shadow register: serial-in shift register, MSB-first, with synchronous clear.
module sb_cfg_shift_reg #(
  parameter int unsigned W = 48
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  // Clear wins over shift; each enabled cycle pushes one bit in at the LSB.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/sb_config_loader.sv
// Serial configuration writer for a column of switch boxes. Bits are shifted
// into a shadow register and committed to c_out in a single edge, so the
// switch boxes never observe a partially loaded frame.
module sb_config_loader
  import sb_cfg_pkg::*;
#(
  parameter int unsigned NUM_ELEM = 4,
  parameter int unsigned CFG_W    = sb_cfg_pkg::CFG_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sb_config_loader_if.slave         cfg,
  output logic [NUM_ELEM*CFG_W-1:0] c_out
);

  localparam int unsigned TOTAL = NUM_ELEM * CFG_W;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  cfg_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [TOTAL-1:0] shadow;
  logic             done_q;
  logic             beat;
  logic             shadow_clr;

  assign cfg.cfg_ready = (state == LOAD);
  assign cfg.busy      = (state != IDLE);
  assign cfg.cfg_done  = done_q;

  // Abort takes priority over a simultaneous beat, so it also blocks the shift.
  assign beat       = (state == LOAD) && cfg.cfg_valid && !cfg.cfg_abort;
  assign shadow_clr = !rst_n || ((state == IDLE) && cfg.cfg_start);

  sb_cfg_shift_reg #(
    .W (TOTAL)
  ) u_shadow (
    .clk (clk),
    .clr (shadow_clr),
    .en  (beat),
    .din (cfg.cfg_bit),
    .q   (shadow)
  );

  // Load sequencing, bit counting and the atomic commit of the shadow frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      c_out  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (cfg.cfg_abort) begin
            state <= IDLE;
          end else if (cfg.cfg_valid) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(TOTAL - 1)) begin
              state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          c_out  <= shadow;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
